mux_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 4:1 mux datapath between four requesters.
- Arbitrates the req lines and drives the mux select (sel[1:0]) for one owner at a time.
- Holds the grant for a multi-beat transfer, then releases it and passes priority on.
- Registers the selected data word. Sits directly in front of the existing mux top and replaces its free-running select stimulus with arbitrated control.

---
 rtl/mux_sched_pkg.sv | 13 +
 rtl/rr_pick4.sv | 31 +++
 rtl/mux_rr_scheduler.sv | 155 +++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler and its arbiter helpers.
package mux_sched_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin pick: first set req bit scanning upward from ptr, wrapping 3->0.
module rr_pick4
    import mux_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [N_REQ-1:0] rot;

    // rot[k] is the request sitting k positions above ptr
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req[SEL_W'(ptr + SEL_W'(gi))];
        end
    endgenerate

    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                winner = ptr + SEL_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a shared 4:1 mux with registered select and data output.
// Optional MUX_SCHED_TIMEOUT_EN adds a MAX_BURST beat limit and the timeout_err pulse.
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DATA_W = 4
`ifdef MUX_SCHED_TIMEOUT_EN
    ,
    parameter int MAX_BURST = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  last,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    output logic [N_REQ-1:0]  grant,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid
`ifdef MUX_SCHED_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic               sel_valid_reg, sel_valid_next;
    logic [DATA_W-1:0]  dout_reg, dout_next;
    logic               dout_valid_reg, dout_valid_next;
    logic [SEL_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
`ifdef MUX_SCHED_TIMEOUT_EN
    logic               timeout_reg, timeout_next;
    logic               burst_hit;
`endif

    logic [DATA_W-1:0]  din_arr [N_REQ];
    logic [SEL_W-1:0]   winner;
    logic               any;
    logic               owner_req;
    logic               owner_last;
    logic               release_now;

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .winner (winner),
        .any    (any)
    );

    assign owner_req  = req[sel_reg];
    assign owner_last = last[sel_reg];

`ifdef MUX_SCHED_TIMEOUT_EN
    assign burst_hit   = owner_req && (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
    assign release_now = !owner_req || owner_last || burst_hit;
`else
    assign release_now = !owner_req || owner_last;
`endif

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        sel_next        = sel_reg;
        sel_valid_next  = sel_valid_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        rr_ptr_next     = rr_ptr_reg;
        beat_cnt_next   = beat_cnt_reg;
`ifdef MUX_SCHED_TIMEOUT_EN
        timeout_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (any) begin
                    state_next     = GRANT;
                    grant_next     = N_REQ'(1) << winner;
                    sel_next       = winner;
                    sel_valid_next = 1'b1;
                    beat_cnt_next  = '0;
                end
            end
            GRANT: begin
                if (owner_req) begin
                    dout_next       = din_arr[sel_reg];
                    dout_valid_next = 1'b1;
                    if (beat_cnt_reg != '1) begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
                // sel is left alone on release so the mux keeps its last path
                if (release_now) begin
                    state_next     = IDLE;
                    grant_next     = '0;
                    sel_valid_next = 1'b0;
                    rr_ptr_next    = sel_reg + 1'b1;
`ifdef MUX_SCHED_TIMEOUT_EN
                    timeout_next   = burst_hit && !owner_last;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            sel_reg        <= '0;
            sel_valid_reg  <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            rr_ptr_reg     <= '0;
            beat_cnt_reg   <= '0;
`ifdef MUX_SCHED_TIMEOUT_EN
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            sel_reg        <= sel_next;
            sel_valid_reg  <= sel_valid_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            rr_ptr_reg     <= rr_ptr_next;
            beat_cnt_reg   <= beat_cnt_next;
`ifdef MUX_SCHED_TIMEOUT_EN
            timeout_reg    <= timeout_next;
`endif
        end
    end

    assign grant      = grant_reg;
    assign sel        = sel_reg;
    assign sel_valid  = sel_valid_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
`ifdef MUX_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_reg;
`endif

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler with a dout scoreboard; covers the timeout path when MUX_SCHED_TIMEOUT_EN is defined.
module tb_mux_rr_scheduler;
    import mux_sched_pkg::*;

    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req;
    logic [3:0]        last;
    logic [DATA_W-1:0] din0, din1, din2, din3;
    logic [3:0]        grant;
    logic [1:0]        sel;
    logic              sel_valid;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
`ifdef MUX_SCHED_TIMEOUT_EN
    logic              timeout_err;
`endif

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef MUX_SCHED_TIMEOUT_EN
    mux_rr_scheduler #(.DATA_W(DATA_W), .MAX_BURST(4)) dut (
`else
    mux_rr_scheduler #(.DATA_W(DATA_W)) dut (
`endif
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .last       (last),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .grant      (grant),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef MUX_SCHED_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then reconcile dout against the scoreboard.
    task automatic tick();
        logic [DATA_W-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout_valid", {7'd0, dout_valid}, 8'd1);
            chk("dout", {4'd0, dout}, {4'd0, e});
            $display("beat dout=%h expected=%h", dout, e);
        end else begin
            chk("dout_valid_idle", {7'd0, dout_valid}, 8'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] fair_exp [9];
        rst = 1'b1; req = 4'b1111; last = 4'b0000;
        din0 = 4'h1; din1 = 4'h2; din2 = 4'h4; din3 = 4'h8;

        // Reset held two cycles with all requesting
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_grant", {4'd0, grant}, 8'h00);
            chk("rst_sel_valid", {7'd0, sel_valid}, 8'd0);
        end
        rst = 1'b0;
        tick();
        chk("first_grant", {4'd0, grant}, 8'h01);
        last = 4'b0001; exp_q.push_back(din0);
        tick();
        chk("first_release", {4'd0, grant}, 8'h00);
        req = 4'b0000; last = 4'b0000;
        tick();

        // Single owner, three beats on requester 2
        req = 4'b0100;
        tick();
        chk("single_grant", {4'd0, grant}, 8'h04);
        chk("single_sel", {6'd0, sel}, 8'd2);
        chk("single_sel_valid", {7'd0, sel_valid}, 8'd1);
        din2 = 4'h3; exp_q.push_back(4'h3); tick();
        din2 = 4'h5; exp_q.push_back(4'h5); tick();
        din2 = 4'h7; last = 4'b0100; exp_q.push_back(4'h7); tick();
        chk("single_release", {4'd0, grant}, 8'h00);
        req = 4'b0000; last = 4'b0000;
        tick();

        // Fairness with all four requesting, one-beat transfers
        do_reset();
        fair_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001};
        din0 = 4'hA; din1 = 4'hB; din2 = 4'hC; din3 = 4'hD;
        req = 4'b1111; last = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("fair_grant", {4'd0, grant}, {4'd0, fair_exp[i]});
            case (fair_exp[i])
                4'b0001: exp_q.push_back(din0);
                4'b0010: exp_q.push_back(din1);
                4'b0100: exp_q.push_back(din2);
                4'b1000: exp_q.push_back(din3);
                default: ;
            endcase
        end
        tick();
        req = 4'b0000; last = 4'b0000;
        tick();

        // Owner drop: requester 1 leaves after two beats without last
        req = 4'b0010;
        tick();
        chk("drop_grant", {4'd0, grant}, 8'h02);
        din1 = 4'h6; exp_q.push_back(4'h6); tick();
        din1 = 4'h9; exp_q.push_back(4'h9); tick();
        req = 4'b0000;
        tick();
        chk("drop_release", {4'd0, grant}, 8'h00);
        req = 4'b0011;
        tick();
        chk("drop_next_owner", {4'd0, grant}, 8'h01);
        req = 4'b0000;
        tick();
        tick();

        // Reset during requester 3's beat
        req = 4'b1000;
        tick();
        chk("mid_grant", {4'd0, grant}, 8'h08);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", {4'd0, grant}, 8'h00);
        chk("mid_rst_sel", {6'd0, sel}, 8'd0);
        chk("mid_rst_sel_valid", {7'd0, sel_valid}, 8'd0);
        chk("mid_rst_dout", {4'd0, dout}, 8'd0);
        rst = 1'b0; req = 4'b1111;
        tick();
        chk("mid_ptr_zero", {4'd0, grant}, 8'h01);
        req = 4'b0000;
        tick();
        tick();

`ifdef MUX_SCHED_TIMEOUT_EN
        // Timeout: requester 0 holds past MAX_BURST=4 while requester 2 waits
        do_reset();
        req = 4'b0101; last = 4'b0000;
        tick();
        chk("to_grant", {4'd0, grant}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            din0 = 4'(i + 3); exp_q.push_back(4'(i + 3));
            tick();
            chk("to_err", {7'd0, timeout_err}, (i == 3) ? 8'd1 : 8'd0);
            chk("to_grant_hold", {4'd0, grant}, (i == 3) ? 8'h00 : 8'h01);
        end
        tick();
        chk("to_err_clear", {7'd0, timeout_err}, 8'd0);
        chk("to_next_owner", {4'd0, grant}, 8'h04);
        req = 4'b0000;
        tick();
`else
        // No beat limit: a long burst keeps the grant
        do_reset();
        req = 4'b0001; last = 4'b0000;
        tick();
        for (int i = 0; i < 12; i++) begin
            din0 = 4'(i); exp_q.push_back(4'(i));
            tick();
            chk("long_grant", {4'd0, grant}, 8'h01);
        end
        req = 4'b0000;
        tick();
        chk("long_release", {4'd0, grant}, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
